pipelined_adder_tree_acc: RTL and testbench
===========================================

Name: pipelined_adder_tree_acc

Overview:
Parametrised successor to the fixed 8-input registered adder tree. It sums N_INPUTS unsigned words through a binary tree with a configurable pipeline register after every level, carrying a valid bit alongside the data. An optional accumulate mode sums consecutive valid tree results into a running total, and the block emits that total on a framing "last" marker. It sits in the adder_trees datapath family as the reusable reduction/accumulation stage.

Parameters:
ADDER_WIDTH, 8, width of each input operand (unsigned).
LEVELS, 3, tree depth; N_INPUTS = 2**LEVELS (legal 1..5).
ACC_BITS, 8, extra accumulator headroom bits beyond tree result width.
REG_EVERY, 1, register after every REG_EVERY-th tree level (1 = every level); the input register and output register are always present.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input vector valid this cycle.
in_last  in  1  marks final vector of an accumulation frame (ignored when acc_en=0).
acc_en  in  1  1 = accumulate mode, 0 = pass-through tree sum; sampled with in_valid.
in_data  in  N_INPUTS*ADDER_WIDTH  packed operands, operand i at bits [i*ADDER_WIDTH +: ADDER_WIDTH].
out_valid  out  1  out_sum valid this cycle.
out_sum  out  ADDER_WIDTH+LEVELS+ACC_BITS  result, zero-extended tree sum or accumulated total.
out_ovf  out  1  accumulator overflowed during the emitted frame (sticky within frame).

Behaviour:
- Reset (async assert, sync-deassert by system): all pipeline valid bits are 0, out_valid is 0, out_sum is 0, out_ovf is 0, accumulator is 0, and the frame-open flag is 0. Data registers are cleared too.
- Stage 0: in_data, in_valid, in_last and acc_en are registered unconditionally every cycle. There is no backpressure and no stall; a new vector is accepted every cycle.
- Tree: level k adds pairs of operands with width ADDER_WIDTH+k-1 and produces width ADDER_WIDTH+k, so there is no truncation at any level. Registers are placed per REG_EVERY. valid/last/acc_en travel through the matching delay.
- Tree latency T = 1 + ceil(LEVELS/REG_EVERY). Total latency from in_valid to out_valid = T+1 cycles (defaults: 5).
- Pass mode (acc_en=0 at the tree output): out_sum is the zero-extended tree sum, out_valid=1, and out_ovf=0. Any open frame is discarded: the accumulator is cleared and the frame-open flag is cleared.
- Accumulate mode: for each valid tree result, acc <= (frame_open ? acc : 0) + tree_sum, and frame_open <= ~last.
  - If last=1, out_sum = the updated total and out_valid=1. frame_open clears, so the next frame starts from 0.
  - If last=0, out_valid=0.
  - out_ovf is 1 if a carry out of the accumulator MSB occurred on any add in the frame. The accumulator wraps modulo 2^width on overflow.
- Invalid cycles (valid=0) leave acc, frame_open and the overflow flag unchanged. out_valid=0 on those cycles, and out_sum holds its last value.
- A single-vector frame (valid & last with frame closed) outputs tree_sum; this is identical to pass mode except for out_ovf semantics.
- Reset mid-frame discards the partial accumulation and all in-flight pipeline contents; no output is produced for them.
- A mode switch mid-frame is treated per-sample as described above; it is not an error.

Test Plan:
- Pass mode, defaults, all 8 operands = 255 with one valid pulse -> 5 cycles later out_valid=1 for one cycle, out_sum=2040, out_ovf=0.
- Back-to-back pass vectors {1..8}, then all-zero, then all-1 on consecutive cycles -> three consecutive out_valid cycles with out_sum=36, 0, 8.
- Accumulate frame of 4 vectors, each all-1, with last on the 4th, and 2 idle cycles inserted between vectors -> a single out_valid with out_sum=32. No output on non-last samples.
- ACC_BITS=0, accumulate 2 vectors of all-255 (2040 each, 11-bit field) -> out_sum=4080 mod 2048=2032, out_ovf=1. The next frame of one all-zero vector -> out_sum=0, out_ovf=0.
- Assert rst_n low for one cycle while a 3-vector frame is in flight -> no out_valid. A subsequent single-vector frame of all-2 -> out_sum=16.
- LEVELS=1, REG_EVERY=1, ADDER_WIDTH=4: operands 15+15 -> latency 3, out_sum=30. Also run LEVELS=4, REG_EVERY=2 with 16x1 -> latency 4, out_sum=16.

Source files
------------

// File: rtl/pipelined_adder_tree_acc.sv
// Pipelined binary adder tree over 2**LEVELS unsigned operands, with an optional
// framed accumulator on the tree output that emits the running total on "last".
module pipelined_adder_tree_acc #(
  parameter int ADDER_WIDTH = 8,
  parameter int LEVELS      = 3,
  parameter int ACC_BITS    = 8,
  parameter int REG_EVERY   = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   in_valid_i,
  input  logic                                   in_last_i,
  input  logic                                   acc_en_i,
  input  logic [(2**LEVELS)*ADDER_WIDTH-1:0]     in_data_i,
  output logic                                   out_valid_o,
  output logic [ADDER_WIDTH+LEVELS+ACC_BITS-1:0] out_sum_o,
  output logic                                   out_ovf_o
);
  localparam int N      = 2**LEVELS;
  localparam int TW     = ADDER_WIDTH + LEVELS;
  localparam int SW     = TW + ACC_BITS;
  localparam int SW1    = SW + 1;
  localparam int STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  typedef struct packed {
    logic vld;
    logic last;
    logic acc;
  } sb_t;

  // Sideband shift register: [0] is the input register, [STAGES] lines up with the tree root.
  sb_t             sb_in;
  sb_t [STAGES:0]  vld_pipe;

  assign sb_in = '{vld: in_valid_i, last: in_last_i, acc: acc_en_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[STAGES-1:0], sb_in};
  end

  // Every node is carried at the full tree width, so no level can truncate.
  genvar k;
  for (k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int W = N >> k;
    logic [TW-1:0] nd [W];

    if (k == 0) begin : g_in
      logic [N*ADDER_WIDTH-1:0] data_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) data_q <= '0;
        else         data_q <= in_data_i;
      end

      always_comb begin
        for (int i = 0; i < W; i++) nd[i] = TW'(data_q[i*ADDER_WIDTH +: ADDER_WIDTH]);
      end
    end else begin : g_add
      localparam bit REG = ((k % REG_EVERY) == 0) || (k == LEVELS);
      logic [TW-1:0] sum_d [W];

      always_comb begin
        for (int i = 0; i < W; i++) sum_d[i] = g_lvl[k-1].nd[2*i] + g_lvl[k-1].nd[2*i+1];
      end

      if (REG) begin : g_reg
        logic [TW-1:0] sum_q [W];

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            for (int i = 0; i < W; i++) sum_q[i] <= '0;
          end else begin
            sum_q <= sum_d;
          end
        end

        assign nd = sum_q;
      end else begin : g_comb
        assign nd = sum_d;
      end
    end
  end

  logic [TW-1:0] tree_sum;
  sb_t           tree_sb;

  assign tree_sum = g_lvl[LEVELS].nd[0];
  assign tree_sb  = vld_pipe[STAGES];

  logic [SW-1:0] acc_q, acc_d, acc_base;
  logic          open_q, open_d;
  logic          ovf_q, ovf_d, ovf_run;
  logic [SW:0]   add_w;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] out_sum_q, out_sum_d;
  logic          out_ovf_q, out_ovf_d;

  // A closed frame restarts from zero; the carry flag only survives while the frame is open.
  always_comb begin
    acc_base  = open_q ? acc_q : '0;
    add_w     = {1'b0, acc_base} + SW1'(tree_sum);
    ovf_run   = (open_q & ovf_q) | add_w[SW];
    acc_d     = acc_q;
    open_d    = open_q;
    ovf_d     = ovf_q;
    out_vld_d = 1'b0;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    if (tree_sb.vld) begin
      if (!tree_sb.acc) begin
        acc_d     = '0;
        open_d    = 1'b0;
        ovf_d     = 1'b0;
        out_vld_d = 1'b1;
        out_sum_d = SW'(tree_sum);
        out_ovf_d = 1'b0;
      end else begin
        acc_d  = add_w[SW-1:0];
        open_d = ~tree_sb.last;
        ovf_d  = ovf_run;
        if (tree_sb.last) begin
          out_vld_d = 1'b1;
          out_sum_d = add_w[SW-1:0];
          out_ovf_d = ovf_run;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      open_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      open_q    <= open_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_valid_o = out_vld_q;
  assign out_sum_o   = out_sum_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// Four differently-parameterised instances share one input stream; a per-slot
// expectation table built from the block's rules is compared every cycle.
module tb_pipelined_adder_tree_acc;
  localparam int NI    = 4;
  localparam int NSLOT = 2048;
  localparam int AWV [NI] = '{8, 8, 4, 8};
  localparam int LVV [NI] = '{3, 3, 1, 4};
  localparam int ABV [NI] = '{8, 0, 8, 8};
  localparam int REV [NI] = '{1, 1, 1, 2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vld = 1'b0, lst = 1'b0, acc = 1'b0;
  logic [127:0] din = '0;

  always #5 clk = ~clk;

  logic [18:0]   s0;
  logic [10:0]   s1;
  logic [12:0]   s2;
  logic [19:0]   s3;
  logic [NI-1:0] ov, oo;
  logic [63:0]   osum [NI];

  pipelined_adder_tree_acc u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld), .in_last_i(lst), .acc_en_i(acc),
    .in_data_i(din[63:0]), .out_valid_o(ov[0]), .out_sum_o(s0), .out_ovf_o(oo[0]));
  pipelined_adder_tree_acc #(.ACC_BITS(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld), .in_last_i(lst), .acc_en_i(acc),
    .in_data_i(din[63:0]), .out_valid_o(ov[1]), .out_sum_o(s1), .out_ovf_o(oo[1]));
  pipelined_adder_tree_acc #(.ADDER_WIDTH(4), .LEVELS(1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld), .in_last_i(lst), .acc_en_i(acc),
    .in_data_i(din[7:0]), .out_valid_o(ov[2]), .out_sum_o(s2), .out_ovf_o(oo[2]));
  pipelined_adder_tree_acc #(.LEVELS(4), .REG_EVERY(2)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld), .in_last_i(lst), .acc_en_i(acc),
    .in_data_i(din[127:0]), .out_valid_o(ov[3]), .out_sum_o(s3), .out_ovf_o(oo[3]));

  always_comb begin
    osum[0] = 64'(s0);
    osum[1] = 64'(s1);
    osum[2] = 64'(s2);
    osum[3] = 64'(s3);
  end

  bit     ev [NI][NSLOT];
  longint es [NI][NSLOT];
  bit     eo [NI][NSLOT];
  longint m_acc [NI];
  bit     m_open [NI];
  bit     m_ovf [NI];
  longint hold [NI];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int i);
    return 2 + (LVV[i] + REV[i] - 1) / REV[i];
  endfunction

  function automatic longint tsum(input int i, input logic [127:0] d);
    longint       s = 0;
    logic [127:0] t = d;
    for (int j = 0; j < (1 << LVV[i]); j++) begin
      s += longint'(t[63:0] & ((64'd1 << AWV[i]) - 64'd1));
      t  = t >> AWV[i];
    end
    return s;
  endfunction

  // Process one accepted vector in arrival order and book its result at its output slot.
  task automatic model(input int i, input bit v, input bit l, input bit a, input logic [127:0] d);
    longint ts, mask, tot;
    bit     c;
    int     s;
    if (!v) return;
    ts   = tsum(i, d);
    mask = (longint'(1) << (AWV[i] + LVV[i] + ABV[i])) - 1;
    s    = cyc + lat(i);
    if (!a) begin
      ev[i][s] = 1'b1; es[i][s] = ts; eo[i][s] = 1'b0;
      m_acc[i] = 0; m_open[i] = 1'b0; m_ovf[i] = 1'b0;
    end else begin
      tot       = (m_open[i] ? m_acc[i] : 0) + ts;
      c         = tot > mask;
      m_ovf[i]  = (m_open[i] && m_ovf[i]) || c;
      m_acc[i]  = tot & mask;
      m_open[i] = !l;
      if (l) begin
        ev[i][s] = 1'b1; es[i][s] = m_acc[i]; eo[i][s] = m_ovf[i];
      end
    end
  endtask

  task automatic step(input bit v, input bit l, input bit a, input logic [127:0] d, input bit r = 1'b0);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.valid@%0d", i, cyc), 64'(ov[i]), 64'(ev[i][cyc]));
      if (ev[i][cyc]) hold[i] = es[i][cyc];
      chk($sformatf("u%0d.sum@%0d", i, cyc), osum[i], hold[i]);
      if (ev[i][cyc]) chk($sformatf("u%0d.ovf@%0d", i, cyc), 64'(oo[i]), 64'(eo[i][cyc]));
    end
    if (r) begin
      rst_n = 1'b0; vld = 1'b0; lst = 1'b0; acc = 1'b0; din = '0;
      for (int i = 0; i < NI; i++) begin
        m_acc[i] = 0; m_open[i] = 1'b0; m_ovf[i] = 1'b0; hold[i] = 0;
        for (int s = cyc + 1; s < NSLOT; s++) ev[i][s] = 1'b0;
      end
    end else begin
      rst_n = 1'b1; vld = v; lst = l; acc = a; din = d;
      for (int i = 0; i < NI; i++) model(i, v, l, a, d);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  logic [127:0] ones, bytes1, twos, seq;

  initial begin
    ones   = '1;
    bytes1 = {16{8'h01}};
    twos   = {16{8'h02}};
    seq    = '0;
    for (int j = 0; j < 8; j++) seq[j*8 +: 8] = 8'(j + 1);
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 0; m_open[i] = 1'b0; m_ovf[i] = 1'b0; hold[i] = 0;
    end

    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);
    for (int i = 0; i < NI; i++) chk($sformatf("rst.ovf.u%0d", i), 64'(oo[i]), 64'd0);

    // pass mode, every operand at max
    step(1'b1, 1'b0, 1'b0, ones);
    idle(5);
    chk("plan.pass255.valid", 64'(ov[0]), 64'd1);
    chk("plan.pass255.sum", osum[0], 64'd2040);
    chk("plan.pass255.ovf", 64'(oo[0]), 64'd0);
    idle(2);
    chk("plan.l1.sum", osum[2], 64'd30);
    chk("plan.l4.sum", osum[3], 64'd4080);

    // back-to-back pass vectors
    step(1'b1, 1'b0, 1'b0, seq);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, bytes1);
    idle(5);
    chk("plan.b2b.last", osum[0], 64'd8);
    chk("plan.l4_16x1", osum[3], 64'd16);
    idle(2);

    // 4-vector accumulate frame with gaps
    for (int n = 0; n < 4; n++) begin
      step(1'b1, n == 3, 1'b1, bytes1);
      if (n < 3) idle(2);
    end
    idle(5);
    chk("plan.acc4.valid", 64'(ov[0]), 64'd1);
    chk("plan.acc4.sum", osum[0], 64'd32);
    idle(2);

    // zero headroom overflow, then a clean single-vector frame
    step(1'b1, 1'b0, 1'b1, ones);
    step(1'b1, 1'b1, 1'b1, ones);
    idle(5);
    chk("plan.ovf.sum", osum[1], 64'd2032);
    chk("plan.ovf.flag", 64'(oo[1]), 64'd1);
    chk("plan.ovf.wide", osum[0], 64'd4080);
    step(1'b1, 1'b1, 1'b1, '0);
    idle(5);
    chk("plan.ovf.next_sum", osum[1], 64'd0);
    chk("plan.ovf.next_flag", 64'(oo[1]), 64'd0);
    idle(2);

    // reset while a frame is in flight
    step(1'b1, 1'b0, 1'b1, bytes1);
    step(1'b1, 1'b0, 1'b1, bytes1);
    step(1'b1, 1'b1, 1'b1, bytes1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b1, twos);
    idle(5);
    chk("plan.rst.valid", 64'(ov[0]), 64'd1);
    chk("plan.rst.sum", osum[0], 64'd16);
    idle(2);

    repeat (500) begin
      logic [127:0] d;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) d = ones;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, d,
           $urandom_range(0, 99) == 0);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
